// File: rtl/lif_tdm_scheduler.sv
// rtl/lif_tdm_scheduler.sv - time-multiplexed LIF neuron ring scheduler
//
// Purpose: shares one leaky-integrate-and-fire update datapath across
// N_NEURONS virtual neurons held in an internal register file. Each sweep
// updates neurons 0..N-1 (one per enabled cycle) and then publishes the
// sweep's spike vector. Neuron i sees neuron (i-1) mod N's spike from the
// previous sweep as a coupling input.
//
// Optional build macro: SPIKE_COUNT_EN adds a saturating spike_count output.
//
// Ports:
//   clk             in   clock
//   rst_n           in   asynchronous active-low reset
//   ena             in   clock enable; all state holds when low
//   run             in   keep sweeping back-to-back while high
//   base_current    in   [4:0] drive added to every neuron update
//   pattern_select  in   [1:0] 00 indep, 01 excite, 10 inhibit, 11 half coupling
//   obs_idx         in   [3:0] neuron shown on obs_potential
//   busy            out  high while a sweep is in progress (UPDATE/COMMIT)
//   cur_idx         out  [3:0] neuron being updated (0 when idle)
//   spike_vec       out  [N_NEURONS-1:0] spikes of the last completed sweep
//   spike_valid     out  pulse marking a fresh spike_vec
//   obs_potential   out  [7:0] stored potential of obs_idx, 0 if out of range
//   spike_count     out  [15:0] total spikes, saturating (SPIKE_COUNT_EN only)

`timescale 1ns/1ps

module lif_tdm_scheduler #(
  parameter int         N_NEURONS = 4,
  parameter logic [7:0] THRESHOLD = 8'd200,
  parameter logic [7:0] RESET_POT = 8'd50,
  parameter logic [7:0] LEAK      = 8'd5,
  parameter logic [3:0] REFRAC    = 4'd10,
  parameter logic [7:0] COUPLE_W  = 8'd16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 run,
  input  logic [4:0]           base_current,
  input  logic [1:0]           pattern_select,
  input  logic [3:0]           obs_idx,
  output logic                 busy,
  output logic [3:0]           cur_idx,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic                 spike_valid,
  output logic [7:0]           obs_potential
`ifdef SPIKE_COUNT_EN
  ,
  output logic [15:0]          spike_count
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] UPDATE = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(N_NEURONS - 1);

  logic [1:0]           state;
  logic [7:0]           pot  [N_NEURONS];
  logic [3:0]           refr [N_NEURONS];
  logic [N_NEURONS-1:0] spike_acc;

  // nbr_vec[i] is the previous-sweep spike of neuron (i-1) mod N.
  logic [N_NEURONS-1:0] nbr_vec;
  assign nbr_vec = {spike_vec[N_NEURONS-2:0], spike_vec[N_NEURONS-1]};

  assign busy = (state != IDLE);

  // Read port for the neuron under update.
  logic [7:0] cur_pot;
  logic [3:0] cur_ref;
  logic       nbr_spike;

  always_comb begin
    cur_pot   = '0;
    cur_ref   = '0;
    nbr_spike = 1'b0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (cur_idx == 4'(i)) begin
        cur_pot   = pot[i];
        cur_ref   = refr[i];
        nbr_spike = nbr_vec[i];
      end
    end
  end

  // Observation port; indices beyond the ring read as 0.
  always_comb begin
    obs_potential = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (obs_idx == 4'(i)) obs_potential = pot[i];
    end
  end

  // Integrate step. A signed intermediate wide enough for the full
  // excite/inhibit range lets the result clamp instead of wrapping.
  logic signed [10:0] coup_s;
  logic signed [10:0] base_s;
  logic signed [10:0] drive_s;
  logic signed [10:0] leak_s;
  logic signed [10:0] sum_s;
  logic [7:0]         integ_pot;

  always_comb begin
    coup_s = nbr_spike ? $signed({3'b000, COUPLE_W}) : 11'sd0;
    base_s = $signed({6'b000000, base_current});
    case (pattern_select)
      2'b00:   drive_s = base_s;
      2'b01:   drive_s = base_s + (coup_s <<< 1);
      2'b10:   drive_s = base_s - (coup_s <<< 2);
      default: drive_s = base_s + (coup_s >>> 1);
    endcase
    leak_s = (cur_pot > LEAK) ? $signed({3'b000, LEAK}) : 11'sd0;
    sum_s  = $signed({3'b000, cur_pot}) + drive_s - leak_s;
    if (sum_s < 11'sd0) begin
      integ_pot = 8'd0;
    end else if (sum_s > 11'sd255) begin
      integ_pot = 8'hFF;
    end else begin
      integ_pot = sum_s[7:0];
    end
  end

  // Next neuron state: refractory hold, fire, or integrate. Firing is
  // decided on the stored potential, so a crossing fires one sweep later.
  logic [7:0] new_pot;
  logic [3:0] new_ref;
  logic       new_spike;

  always_comb begin
    new_pot   = integ_pot;
    new_ref   = 4'd0;
    new_spike = 1'b0;
    if (cur_ref != 4'd0) begin
      new_pot = RESET_POT;
      new_ref = cur_ref - 4'd1;
    end else if (cur_pot >= THRESHOLD) begin
      new_pot   = RESET_POT;
      new_ref   = REFRAC;
      new_spike = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_idx     <= 4'd0;
      spike_vec   <= '0;
      spike_acc   <= '0;
      spike_valid <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        pot[i]  <= RESET_POT;
        refr[i] <= 4'd0;
      end
    end else if (ena) begin
      spike_valid <= 1'b0;
      case (state)
        IDLE: begin
          cur_idx <= 4'd0;
          if (run) state <= UPDATE;
        end
        UPDATE: begin
          for (int i = 0; i < N_NEURONS; i++) begin
            if (cur_idx == 4'(i)) begin
              pot[i]  <= new_pot;
              refr[i] <= new_ref;
              if (new_spike) spike_acc[i] <= 1'b1;
            end
          end
          if (cur_idx == LAST_IDX) begin
            state   <= COMMIT;
            cur_idx <= 4'd0;
          end else begin
            cur_idx <= cur_idx + 4'd1;
          end
        end
        COMMIT: begin
          // spike_valid rises together with the new spike_vec.
          spike_vec   <= spike_acc;
          spike_acc   <= '0;
          spike_valid <= 1'b1;
          cur_idx     <= 4'd0;
          state       <= run ? UPDATE : IDLE;
        end
        default: begin
          state   <= IDLE;
          cur_idx <= 4'd0;
        end
      endcase
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [4:0]  sweep_pop;
  logic [16:0] count_sum;

  always_comb begin
    sweep_pop = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      sweep_pop = sweep_pop + {4'b0000, spike_acc[i]};
    end
    count_sum = {1'b0, spike_count} + {12'd0, sweep_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_count <= '0;
    end else if (ena && state == COMMIT) begin
      spike_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// tb/tb_lif_tdm_scheduler.sv - scoreboard bench for lif_tdm_scheduler

`timescale 1ns/1ps

module tb_lif_tdm_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         run;
  logic [4:0]   base_current;
  logic [1:0]   pattern_select;
  logic [3:0]   obs_idx;
  logic         busy;
  logic [3:0]   cur_idx;
  logic [N-1:0] spike_vec;
  logic         spike_valid;
  logic [7:0]   obs_potential;
`ifdef SPIKE_COUNT_EN
  logic [15:0]  spike_count;
`endif

  always #5 clk = ~clk;

  lif_tdm_scheduler #(.N_NEURONS(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .run            (run),
    .base_current   (base_current),
    .pattern_select (pattern_select),
    .obs_idx        (obs_idx),
    .busy           (busy),
    .cur_idx        (cur_idx),
    .spike_vec      (spike_vec),
    .spike_valid    (spike_valid),
    .obs_potential  (obs_potential)
`ifdef SPIKE_COUNT_EN
    ,
    .spike_count    (spike_count)
`endif
  );

  typedef struct {
    logic [3:0] vec;
    logic [7:0] pot;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   cyc      = 0;
  int   last_pulse = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: each rising spike_valid pops one expected sweep result.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (spike_valid === 1'b1 && !prev_valid) begin
      pulses++;
      check($sformatf("pulse%0d_expected", pulses), 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("pulse%0d_spike_vec", pulses), 32'(spike_vec), 32'(e.vec));
        check($sformatf("pulse%0d_obs_potential", pulses), 32'(obs_potential), 32'(e.pot));
        if (e.gap != 0)
          check($sformatf("pulse%0d_period", pulses), cyc - last_pulse, e.gap);
      end
      last_pulse = cyc;
    end
    prev_valid = spike_valid;
  end

  task automatic push_exp(input logic [3:0] vec, input logic [7:0] pot, input int gap);
    exp_t e;
    e.vec = vec;
    e.pot = pot;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int k = 0;
    while (pulses < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("wait_pulse%0d", target), 32'(pulses >= target), 1);
  endtask

  task automatic wait_idx(input logic [3:0] idx, input int budget);
    int  k = 0;
    logic hit = 1'b0;
    while (!hit && k < budget) begin
      @(negedge clk);
      k++;
      hit = busy && (cur_idx == idx);
    end
    check($sformatf("wait_idx%0d", idx), 32'(hit), 1);
  endtask

  // One isolated sweep with per-neuron base current; called at a negedge
  // while idle, returns at the negedge that shows the spike_valid pulse.
  task automatic do_sweep(input logic [4:0] b0, input logic [4:0] b1,
                          input logic [4:0] b2, input logic [4:0] b3,
                          input logic [1:0] pat, input logic [3:0] obs,
                          input logic [3:0] evec, input logic [7:0] epot);
    push_exp(evec, epot, 0);
    #1;
    obs_idx        = obs;
    pattern_select = pat;
    base_current   = b0;
    run            = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    base_current = b1;
    @(negedge clk);
    base_current = b2;
    @(negedge clk);
    base_current = b3;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    ena            = 1'b1;
    run            = 1'b0;
    base_current   = 5'd0;
    pattern_select = 2'b00;
    obs_idx        = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("idle_busy_c%0d", c), 32'(busy), 0);
      check($sformatf("idle_valid_c%0d", c), 32'(spike_valid), 0);
    end
    check("reset_cur_idx", 32'(cur_idx), 0);
    check("reset_spike_vec", 32'(spike_vec), 0);
    for (int i = 0; i <= N; i++) begin
      obs_idx = 4'(i);
      #1;
      check($sformatf("reset_obs%0d", i), 32'(obs_potential), (i < N) ? 50 : 0);
    end
`ifdef SPIKE_COUNT_EN
    check("reset_spike_count", 32'(spike_count), 0);
`endif

    // Continuous run: ramp, simultaneous spike, refractory, recovery
    @(negedge clk);
    #1;
    obs_idx        = 4'd1;
    base_current   = 5'd10;
    pattern_select = 2'b00;
    for (int k = 1; k <= 42; k++) begin
      if (k <= 30)      push_exp(4'b0000, 8'(50 + 5 * k), (k == 1) ? 0 : 5);
      else if (k == 31) push_exp(4'b1111, 8'd50, 5);
      else if (k <= 41) push_exp(4'b0000, 8'd50, 5);
      else              push_exp(4'b0000, 8'd55, 5);
    end
    run = 1'b1;
    wait_pulses(41, 400);
    wait_idx(4'd2, 10);
    run = 1'b0;
    wait_pulses(42, 20);
    repeat (6) @(negedge clk);
    check("stop_busy", 32'(busy), 0);
    check("stop_cur_idx", 32'(cur_idx), 0);
    check("stop_pulse_count", pulses, 42);
`ifdef SPIKE_COUNT_EN
    check("count_after_ramp", 32'(spike_count), 4);
`endif

    // Excite coupling: neuron 0 fires, neuron 1 gains 2*16 - 5
    for (int s = 1; s <= 6; s++)
      do_sweep(5'd31, 5'd5, 5'd10, 5'd27, 2'b00, 4'd0, 4'b0000, 8'(55 + 26 * s));
    do_sweep(5'd31, 5'd5, 5'd10, 5'd27, 2'b00, 4'd0, 4'b0001, 8'd50);
    do_sweep(5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 4'd1, 4'b1000, 8'd82);

    // Reset in the middle of a sweep
    #1;
    base_current   = 5'd0;
    pattern_select = 2'b00;
    run            = 1'b1;
    wait_idx(4'd1, 10);
    check("pre_reset_spike_vec", 32'(spike_vec), 32'h8);
    rst_n = 1'b0;
    #1;
    check("abort_spike_vec", 32'(spike_vec), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_cur_idx", 32'(cur_idx), 0);
    check("abort_valid", 32'(spike_valid), 0);
`ifdef SPIKE_COUNT_EN
    check("abort_spike_count", 32'(spike_count), 0);
`endif
    for (int i = 0; i < N; i++) begin
      obs_idx = 4'(i);
      #1;
      check($sformatf("abort_obs%0d", i), 32'(obs_potential), 50);
    end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Inhibit coupling clamps at 0 instead of wrapping
    for (int s = 1; s <= 6; s++)
      do_sweep(5'd5, 5'd31, 5'd0, 5'd5, 2'b00, 4'd2, 4'b0000, 8'(50 - 5 * s));
    do_sweep(5'd5, 5'd31, 5'd5, 5'd5, 2'b00, 4'd2, 4'b0010, 8'd20);
    do_sweep(5'd0, 5'd0, 5'd0, 5'd0, 2'b10, 4'd2, 4'b0000, 8'd0);

    // Clock-enable freeze mid-sweep and pulse stretch; potential 0 skips leak
    push_exp(4'b0000, 8'd5, 0);
    #1;
    base_current   = 5'd5;
    pattern_select = 2'b00;
    run            = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    check("freeze_cur_idx", 32'(cur_idx), 1);
    check("freeze_busy", 32'(busy), 1);
    ena = 1'b1;
    begin
      int k = 0;
      while (spike_valid !== 1'b1 && k < 10) begin
        @(negedge clk);
        k++;
      end
    end
    check("freeze_pulse_seen", 32'(spike_valid), 1);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    check("stretch_valid_held", 32'(spike_valid), 1);
    ena = 1'b1;
    repeat (2) @(negedge clk);
    check("stretch_valid_cleared", 32'(spike_valid), 0);
    check("stretch_busy", 32'(busy), 0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
